// File: rtl/if_fetch_stage_pkg.sv
// Shared types and defaults for the instruction-fetch stage (package if_pkg).
// Holds the fetch FSM encoding, the nop word and the PC reset/step defaults.
package if_pkg;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_HELD = 1'b1
    } if_state_e;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
    localparam logic [31:0] IF_PC_STEP  = 32'd4;
    localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;

    // Modulo-2^32 sequential advance; wraps silently past 32'hFFFF_FFFC.
    function automatic logic [31:0] pc_advance(input logic [31:0] pc, input logic [31:0] step);
        return pc + step;
    endfunction

endpackage

// File: rtl/if_fetch_stage_perf_counter.sv
// Saturating event counter used by the fetch stage performance monitors.
// Only instantiated when IF_FETCH_PERF_CNT_EN is defined.
module if_perf_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS IF stage: owns the PC, single-outstanding imem handshake, stall buffer and redirect/kill.
// Define IF_FETCH_PERF_CNT_EN to enable the perf_stall / perf_redirect counters (tied to 0 otherwise).
module if_fetch_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IF_RESET_PC,
    parameter logic [31:0] PC_STEP  = IF_PC_STEP
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pc_write,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction_if,
    output logic [31:0] npc_if,
    output logic        if_valid,
    output logic        fetch_busy,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_redirect
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_pending_q, pc_pending_d;
    logic [31:0] hold_buf_q, hold_buf_d;
    logic        kill_q, kill_d;

    logic        redirect;
    logic [31:0] target;
    logic        deliver;

    assign redirect = branch_taken | jump;
    assign target   = branch_taken ? branch_target : jump_target;

    // Outputs are gated by reset so nothing is requested or presented while it is held low.
    assign imem_req   = reset && (state_q == S_REQ);
    assign fetch_busy = imem_req && !imem_ready;
    assign deliver    = imem_req && imem_ready && !kill_q && !redirect;
    assign if_valid   = deliver || (reset && (state_q == S_HELD) && !redirect);

    assign instruction_if = deliver  ? imem_rdata :
                            if_valid ? hold_buf_q : NOP_INSTR;
    assign imem_addr      = pc_q;
    assign npc_if         = pc_advance(pc_q, PC_STEP);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pc_pending_d = pc_pending_q;
        hold_buf_d   = hold_buf_q;
        kill_d       = kill_q;
        unique case (state_q)
            S_REQ: begin
                if (imem_ready) begin
                    if (redirect) begin
                        pc_d   = target;
                        kill_d = 1'b0;
                    end else if (kill_q) begin
                        pc_d   = pc_pending_q;
                        kill_d = 1'b0;
                    end else if (pc_write) begin
                        pc_d = pc_advance(pc_q, PC_STEP);
                    end else begin
                        hold_buf_d = imem_rdata;
                        state_d    = S_HELD;
                    end
                end else if (redirect) begin
                    // Address must stay stable until the outstanding request completes.
                    kill_d       = 1'b1;
                    pc_pending_d = target;
                end
            end
            S_HELD: begin
                if (redirect) begin
                    pc_d       = target;
                    hold_buf_d = NOP_INSTR;
                    state_d    = S_REQ;
                end else if (pc_write) begin
                    pc_d    = pc_advance(pc_q, PC_STEP);
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            pc_pending_q <= RESET_PC;
            hold_buf_q   <= NOP_INSTR;
            kill_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pc_pending_q <= pc_pending_d;
            hold_buf_q   <= hold_buf_d;
            kill_q       <= kill_d;
        end
    end

`ifdef IF_FETCH_PERF_CNT_EN
    if_perf_counter #(.WIDTH(32)) u_stall_cnt (
        .clk_i  (clock),
        .rst_ni (reset),
        .inc_i  (fetch_busy),
        .count_o(perf_stall)
    );

    if_perf_counter #(.WIDTH(32)) u_redirect_cnt (
        .clk_i  (clock),
        .rst_ni (reset),
        .inc_i  (redirect),
        .count_o(perf_redirect)
    );
`else
    assign perf_stall    = '0;
    assign perf_redirect = '0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed self-checking bench for if_fetch_stage: sequential fetch, wait states,
// stall buffering, redirect/kill, PC wrap, async reset and the optional perf counters.
module tb_if_fetch_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        pc_write;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instruction_if;
    logic [31:0] npc_if;
    logic        if_valid;
    logic        fetch_busy;
    logic [31:0] perf_stall;
    logic [31:0] perf_redirect;

    int tests = 0;
    int fails = 0;

    if_fetch_stage #(
        .RESET_PC(32'h0000_0000),
        .PC_STEP (32'd4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .pc_write      (pc_write),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .instruction_if(instruction_if),
        .npc_if        (npc_if),
        .if_valid      (if_valid),
        .fetch_busy    (fetch_busy),
        .perf_stall    (perf_stall),
        .perf_redirect (perf_redirect)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; pc_write = 1'b1; branch_taken = 1'b0; jump = 1'b0;
        branch_target = '0; jump_target = '0;
        imem_ready = 1'b1; imem_rdata = 32'hC0DE_0000;
        #12;
        tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b expected 0", if_valid); end
        tests++; if (instruction_if !== 32'h0) begin fails++; $display("FAIL rst_instr: got %h expected 00000000", instruction_if); end
        tests++; if (fetch_busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b expected 0", fetch_busy); end
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_req: got %b expected 0", imem_req); end
        tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL rst_addr: got %h expected 00000000", imem_addr); end
        @(negedge clock);
        reset = 1'b1;
        #1;
        tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL rel_req: got %b expected 1", imem_req); end
    endtask

    task automatic test_zero_wait();
        for (int i = 0; i < 4; i++) begin
            logic [31:0] exp_addr;
            exp_addr   = 32'(i) * 32'd4;
            imem_ready = 1'b1;
            imem_rdata = 32'hC0DE_0000 | exp_addr;
            #1;
            tests++; if (imem_addr !== exp_addr) begin fails++; $display("FAIL zw_addr[%0d]: got %h expected %h", i, imem_addr, exp_addr); end
            tests++; if (npc_if !== exp_addr + 32'd4) begin fails++; $display("FAIL zw_npc[%0d]: got %h expected %h", i, npc_if, exp_addr + 32'd4); end
            tests++; if (if_valid !== 1'b1) begin fails++; $display("FAIL zw_valid[%0d]: got %b expected 1", i, if_valid); end
            tests++; if (instruction_if !== (32'hC0DE_0000 | exp_addr)) begin fails++; $display("FAIL zw_instr[%0d]: got %h expected %h", i, instruction_if, 32'hC0DE_0000 | exp_addr); end
            tick();
        end
    endtask

    task automatic test_wait_states();
        imem_ready = 1'b0;
        imem_rdata = 32'hFFFF_FFFF;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests++; if (fetch_busy !== 1'b1) begin fails++; $display("FAIL ws_busy[%0d]: got %b expected 1", c, fetch_busy); end
            tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL ws_valid[%0d]: got %b expected 0", c, if_valid); end
            tests++; if (instruction_if !== 32'h0) begin fails++; $display("FAIL ws_instr[%0d]: got %h expected 00000000", c, instruction_if); end
            tests++; if (imem_addr !== 32'h10) begin fails++; $display("FAIL ws_addr[%0d]: got %h expected 00000010", c, imem_addr); end
            tick();
        end
        imem_ready = 1'b1;
        imem_rdata = 32'h2402_0010;
        #1;
        tests++; if (if_valid !== 1'b1) begin fails++; $display("FAIL ws_deliver: got %b expected 1", if_valid); end
        tests++; if (instruction_if !== 32'h2402_0010) begin fails++; $display("FAIL ws_data: got %h expected 24020010", instruction_if); end
        tests++; if (fetch_busy !== 1'b0) begin fails++; $display("FAIL ws_busy_end: got %b expected 0", fetch_busy); end
        tick();
        tests++; if (imem_addr !== 32'h14) begin fails++; $display("FAIL ws_next: got %h expected 00000014", imem_addr); end
    endtask

    task automatic test_jump_redirect();
        imem_ready  = 1'b1;
        imem_rdata  = 32'h1234_5678;
        jump        = 1'b1;
        jump_target = 32'h0000_0020;
        #1;
        tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL jmp_valid: got %b expected 0", if_valid); end
        tests++; if (instruction_if !== 32'h0) begin fails++; $display("FAIL jmp_instr: got %h expected 00000000", instruction_if); end
        tick();
        jump = 1'b0;
        #1;
        tests++; if (imem_addr !== 32'h20) begin fails++; $display("FAIL jmp_addr: got %h expected 00000020", imem_addr); end
    endtask

    task automatic test_perf();
`ifdef IF_FETCH_PERF_CNT_EN
        tests++; if (perf_stall !== 32'd3) begin fails++; $display("FAIL perf_stall: got %0d expected 3", perf_stall); end
        tests++; if (perf_redirect !== 32'd1) begin fails++; $display("FAIL perf_redirect: got %0d expected 1", perf_redirect); end
`else
        tests++; if (perf_stall !== 32'd0) begin fails++; $display("FAIL perf_stall: got %0d expected 0", perf_stall); end
        tests++; if (perf_redirect !== 32'd0) begin fails++; $display("FAIL perf_redirect: got %0d expected 0", perf_redirect); end
`endif
    endtask

    task automatic test_branch_pending();
        imem_ready    = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0100;
        jump          = 1'b1;
        jump_target   = 32'h0000_0200;
        #1;
        tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL br_valid0: got %b expected 0", if_valid); end
        tests++; if (imem_addr !== 32'h20) begin fails++; $display("FAIL br_addr0: got %h expected 00000020", imem_addr); end
        tick();
        branch_taken = 1'b0;
        jump         = 1'b0;
        #1;
        tests++; if (imem_addr !== 32'h20) begin fails++; $display("FAIL br_addr_stable: got %h expected 00000020", imem_addr); end
        tests++; if (fetch_busy !== 1'b1) begin fails++; $display("FAIL br_busy: got %b expected 1", fetch_busy); end
        tick();
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL br_killed_valid: got %b expected 0", if_valid); end
        tests++; if (instruction_if !== 32'h0) begin fails++; $display("FAIL br_killed_instr: got %h expected 00000000", instruction_if); end
        tick();
        tests++; if (imem_addr !== 32'h100) begin fails++; $display("FAIL br_target: got %h expected 00000100", imem_addr); end
        imem_rdata = 32'hAAAA_0100;
        #1;
        tests++; if (if_valid !== 1'b1) begin fails++; $display("FAIL br_resume: got %b expected 1", if_valid); end
        tick();
    endtask

    task automatic test_hold();
        imem_ready = 1'b1;
        imem_rdata = 32'h8C41_0004;
        pc_write   = 1'b0;
        #1;
        tests++; if (instruction_if !== 32'h8C41_0004) begin fails++; $display("FAIL hold_deliver: got %h expected 8c410004", instruction_if); end
        tick();
        imem_ready = 1'b0;
        imem_rdata = 32'h0BAD_0BAD;
        for (int c = 0; c < 2; c++) begin
            pc_write = (c == 1);
            #1;
            tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL hold_req[%0d]: got %b expected 0", c, imem_req); end
            tests++; if (if_valid !== 1'b1) begin fails++; $display("FAIL hold_valid[%0d]: got %b expected 1", c, if_valid); end
            tests++; if (instruction_if !== 32'h8C41_0004) begin fails++; $display("FAIL hold_instr[%0d]: got %h expected 8c410004", c, instruction_if); end
            tests++; if (imem_addr !== 32'h104) begin fails++; $display("FAIL hold_addr[%0d]: got %h expected 00000104", c, imem_addr); end
            tick();
        end
        tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL hold_rereq: got %b expected 1", imem_req); end
        tests++; if (imem_addr !== 32'h108) begin fails++; $display("FAIL hold_adv: got %h expected 00000108", imem_addr); end
    endtask

    task automatic test_wrap();
        imem_ready  = 1'b1;
        jump        = 1'b1;
        jump_target = 32'hFFFF_FFFC;
        tick();
        jump = 1'b0;
        imem_rdata = 32'h0000_0020;
        #1;
        tests++; if (npc_if !== 32'h0) begin fails++; $display("FAIL wrap_npc: got %h expected 00000000", npc_if); end
        tests++; if (if_valid !== 1'b1) begin fails++; $display("FAIL wrap_valid: got %b expected 1", if_valid); end
        tick();
        tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL wrap_addr: got %h expected 00000000", imem_addr); end
    endtask

    task automatic test_reset_mid_held();
        imem_ready = 1'b1;
        imem_rdata = 32'h0000_0001;
        pc_write   = 1'b1;
        tick();
        imem_rdata = 32'h8C42_0008;
        pc_write   = 1'b0;
        tick();
        imem_ready = 1'b0;
        #1;
        tests++; if (if_valid !== 1'b1) begin fails++; $display("FAIL rmh_held: got %b expected 1", if_valid); end
        reset = 1'b0;
        #1;
        tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL rmh_valid: got %b expected 0", if_valid); end
        tests++; if (instruction_if !== 32'h0) begin fails++; $display("FAIL rmh_instr: got %h expected 00000000", instruction_if); end
        tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL rmh_addr: got %h expected 00000000", imem_addr); end
        @(negedge clock);
        pc_write = 1'b1;
        reset    = 1'b1;
        #1;
        tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL rmh_req: got %b expected 1", imem_req); end
        tests++; if (fetch_busy !== 1'b1) begin fails++; $display("FAIL rmh_busy: got %b expected 1", fetch_busy); end
        imem_ready = 1'b1;
        imem_rdata = 32'hC0DE_0000;
        #1;
        tests++; if (if_valid !== 1'b1) begin fails++; $display("FAIL rmh_first: got %b expected 1", if_valid); end
        tick();
    endtask

    task automatic test_reset_mid_kill();
        imem_ready    = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0300;
        tick();
        branch_taken = 1'b0;
        reset = 1'b0;
        #2;
        imem_ready = 1'b1;
        imem_rdata = 32'hC0DE_0000;
        @(negedge clock);
        reset = 1'b1;
        #1;
        tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL rmk_addr: got %h expected 00000000", imem_addr); end
        tests++; if (if_valid !== 1'b1) begin fails++; $display("FAIL rmk_kill_clear: got %b expected 1", if_valid); end
        tick();
        tests++; if (imem_addr !== 32'h4) begin fails++; $display("FAIL rmk_next: got %h expected 00000004", imem_addr); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_jump_redirect();
        test_perf();
        test_branch_pending();
        test_hold();
        test_wrap();
        test_reset_mid_held();
        test_reset_mid_kill();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline; sits directly upstream of the IF/ID pipeline register.
- Owns the PC and runs a single-outstanding req/ready handshake with instruction memory.
- Presents instruction_if and npc_if = PC+4 combinationally to IF/ID.
- Buffers a returned instruction while the hazard unit stalls, and applies branch/jump redirects with kill of in-flight fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
PC_STEP, 4, byte increment between sequential instructions.

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
pc_write  input  1  hazard unit: 1 = PC may advance, 0 = hold fetch
branch_taken  input  1  redirect request from branch resolution
branch_target  input  32  branch destination
jump  input  1  redirect request for j/jal
jump_target  input  32  jump destination
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  fetch address, equal to pc
imem_ready  input  1  memory returns imem_rdata for outstanding request this cycle
imem_rdata  input  32  fetched word
instruction_if  output  32  instruction to IF/ID; 32'h0 (nop) when if_valid=0
npc_if  output  32  pc+PC_STEP, combinational
if_valid  output  1  instruction_if is a real instruction this cycle
fetch_busy  output  1  request outstanding and not ready; hazard unit uses it to freeze downstream

Behaviour:
- Reset (async, reset=0): pc=RESET_PC; state=S_REQ; kill=0; hold_buf=0.
  - Outputs during reset: imem_req=1 once reset deasserts; instruction_if=0, if_valid=0, fetch_busy=0.
- S_REQ: imem_req=1, imem_addr=pc, held stable until imem_ready.
  - fetch_busy = !imem_ready.
  - Delivery condition: imem_ready & !kill & !redirect.
    - If delivered: instruction_if=imem_rdata, if_valid=1.
    - Else: instruction_if=0, if_valid=0.
  - Delivery with pc_write=1: pc<=pc+PC_STEP at the edge; stay S_REQ, so a back-to-back fetch of 1 instr/cycle is possible.
  - Delivery with pc_write=0: hold_buf<=imem_rdata; go S_HELD; pc unchanged.
- S_HELD: imem_req=0; instruction_if=hold_buf, if_valid=1.
  - When pc_write=1: pc<=pc+PC_STEP; go S_REQ.
- Redirect: redirect=branch_taken|jump; target=branch_taken ? branch_target : jump_target. Branch wins when both are asserted.
  - In any state, redirect forces if_valid=0 that cycle; pc<=target at the edge regardless of pc_write.
  - Redirect in S_HELD: drop hold_buf; go S_REQ.
  - Redirect in S_REQ with imem_ready=1: data discarded; next cycle requests target.
  - Redirect in S_REQ with imem_ready=0: address must stay stable. Set kill=1, keep imem_addr=old pc, and store the target in pc_pending.
    - On the ready of the killed request: discard data, clear kill, load pc<=pc_pending.
  - A second redirect while kill=1 overwrites pc_pending.
- pc_write=0 while waiting (S_REQ, not ready): no effect until data returns.
- Width: pc arithmetic is modulo 2^32; wrap at 32'hFFFF_FFFC -> 0 with no flag.
- All state updates occur on the posedge clock; the only asynchronous path is reset.
- Output and ready timing:
  - Outputs other than pc-derived ones are combinational from state and imem inputs; no extra latency is added beyond the memory's.
  - Zero-wait memory (ready in the request cycle) gives 1 instruction per cycle.

Optional Feature:
- Macro IF_FETCH_PERF_CNT_EN.
- Defined:
  - Adds 32-bit saturating counters stall_cycles (counts fetch_busy cycles) and redirect_count (counts redirect cycles).
  - Exposed as outputs perf_stall[31:0] and perf_redirect[31:0]; both reset to 0.
- Undefined: the ports remain, tied to 32'h0; no counter flops are inferred.

Decomposition:
- Shared package if_pkg:
  - state enum S_REQ/S_HELD (1-bit)
  - NOP_INSTR=32'h0
  - PC_STEP default
  - RESET_PC default
- One natural sub-module, if_perf_counter: a saturating counter instanced twice under the macro.
- PC/FSM logic stays in the top module.

Test Plan:
- Reset release, zero-wait memory returning addr-tagged data -> if_valid=1 every cycle; imem_addr 0,4,8,...; npc_if=imem_addr+4.
- imem_ready delayed 3 cycles -> fetch_busy=1 for 3 cycles, if_valid=0, instruction_if=0, imem_addr stable; delivery on cycle 4.
- pc_write=0 for 2 cycles during delivery of 32'h8C410004 -> S_HELD; instruction_if stays 32'h8C410004 with imem_req=0; pc advances once pc_write=1.
- branch_taken with target 32'h0000_0100 while request to 0x20 is pending (ready 2 cycles later):
  - returned data discarded (if_valid=0);
  - next imem_addr=0x100.
  - Also assert jump in the same cycle -> branch_target wins.
- Assert reset mid-wait, with S_HELD holding data -> pc=RESET_PC, if_valid=0, kill cleared; first request after release is to RESET_PC.
- With IF_FETCH_PERF_CNT_EN defined, the above sequence -> perf_stall=3, perf_redirect=1; without the macro -> both read 0.
